// File: rtl/sound_dma_pkg.sv
// Shared types for the Sound Blaster DMA arbiter.
// Optional timeout/abort logic is enabled by SOUND_DMA_TIMEOUT_EN.
package sound_dma_pkg;

  localparam int BURST_W = 4;

  localparam logic CH1 = 1'b0;
  localparam logic CH5 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RECOV = 2'd2
  } state_e;

  typedef enum logic {
    RQ8  = 1'b0,
    RQ16 = 1'b1
  } rq_e;

  function automatic rq_e other(input rq_e r);
    return (r == RQ8) ? RQ16 : RQ8;
  endfunction

endpackage

// File: rtl/sound_dma_rr.sv
// Two-way round-robin picker for the 8/16-bit DMA requesters.
// A requester keeps winning ties until it has used BURST_MAX grants in a row.
module sound_dma_rr
  import sound_dma_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req8,
  input  logic req16,
  input  logic take,
  output rq_e  winner,
  output logic valid
);

  localparam logic [BURST_W-1:0] LIMIT = BURST_W'(BURST_MAX);

  rq_e               last_q, last_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;

  assign valid = req8 | req16;

  always_comb begin
    winner = last_q;
    unique case ({req16, req8})
      2'b01:   winner = RQ8;
      2'b10:   winner = RQ16;
      2'b11:   winner = (cnt_q >= LIMIT) ? other(last_q) : last_q;
      default: winner = last_q;
    endcase
  end

  // Count saturates at the limit so a long solo run still yields on a tie.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (take) begin
      last_d = winner;
      if (winner != last_q) begin
        cnt_d = BURST_W'(1);
      end else if (cnt_q < LIMIT) begin
        cnt_d = cnt_q + BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= RQ8;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sound_dma_arb.sv
// Sound Blaster DSP 8/16-bit DMA arbiter onto system channels 1 and 5.
// Define SOUND_DMA_TIMEOUT_EN to abort grants that never see dma_ack.
module sound_dma_arb
  import sound_dma_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_16_en,
  input  logic        dsp_req8,
  input  logic        dsp_req16,
  output logic        dsp_ack8,
  output logic        dsp_ack16,
  output logic [15:0] dsp_readdata,
  input  logic [15:0] dsp_writedata,
  output logic        dma_req8,
  output logic        dma_req16,
  input  logic        dma_ack,
  input  logic [15:0] dma_readdata,
  output logic [15:0] dma_writedata,
  output logic        busy,
  output logic        err,
  input  logic        err_clr
);

  state_e      state_q, state_d;
  rq_e         winner, win_q;
  logic        valid;
  logic        take;
  logic        gnt_ack;
  logic        tmo_exp;
  logic        route_q;
  logic        ack8_q, ack16_q;
  logic [15:0] rdata_q, wdata_q;

  assign take    = (state_q == IDLE) && valid;
  assign gnt_ack = (state_q == GRANT) && dma_ack;

  sound_dma_rr #(
    .BURST_MAX(BURST_MAX)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req8  (dsp_req8),
    .req16 (dsp_req16),
    .take  (take),
    .winner(winner),
    .valid (valid)
  );

`ifdef SOUND_DMA_TIMEOUT_EN
  logic [12:0] tmo_q;
  logic        err_q;

  // Ack in the expiry cycle takes priority over the abort.
  assign tmo_exp = (state_q == GRANT) && !dma_ack
                && (tmo_q == 13'(TIMEOUT - 1));
  assign err     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == GRANT) ? tmo_q + 13'd1 : 13'd0;
      if (tmo_exp) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = err_clr ^ (TIMEOUT == 0);
  assign tmo_exp    = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid) state_d = GRANT;
      GRANT:   if (dma_ack || tmo_exp) state_d = RECOV;
      RECOV:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dma_req8  = 1'b0;
    dma_req16 = 1'b0;
    if (state_q == GRANT) begin
      dma_req8  = (route_q == CH1);
      dma_req16 = (route_q == CH5);
    end
    busy = (state_q != IDLE);
  end

  // Route is frozen at grant time; later dma_16_en changes wait for IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= RQ8;
      route_q <= CH1;
      wdata_q <= '0;
      rdata_q <= '0;
      ack8_q  <= 1'b0;
      ack16_q <= 1'b0;
    end else begin
      if (take) begin
        win_q   <= winner;
        route_q <= (winner == RQ16 && dma_16_en) ? CH5 : CH1;
        wdata_q <= dsp_writedata;
      end
      if (gnt_ack) begin
        rdata_q <= dma_readdata;
      end
      ack8_q  <= gnt_ack && (win_q == RQ8);
      ack16_q <= gnt_ack && (win_q == RQ16);
    end
  end

  assign dsp_ack8      = ack8_q;
  assign dsp_ack16     = ack16_q;
  assign dsp_readdata  = rdata_q;
  assign dma_writedata = wdata_q;

endmodule

// File: tb/tb_sound_dma_arb.sv
// Directed bench for sound_dma_arb: vector table plus corner sequences.
// Timeout sequence runs only when SOUND_DMA_TIMEOUT_EN is defined.
module tb_sound_dma_arb;

  logic        clk;
  logic        rst;
  logic        dma_16_en;
  logic        dsp_req8, dsp_req16;
  logic        dsp_ack8, dsp_ack16;
  logic [15:0] dsp_readdata, dsp_writedata;
  logic        dma_req8, dma_req16;
  logic        dma_ack;
  logic [15:0] dma_readdata, dma_writedata;
  logic        busy, err, err_clr;

  int n_run  = 0;
  int n_fail = 0;
  bit dual   = 1'b0;

  typedef struct {
    logic        r8, r16, en;
    logic [15:0] wd, rd;
    logic        e8, e16, a8, a16;
  } vec_t;

  vec_t vt[12];

  sound_dma_arb #(
    .BURST_MAX(4),
    .TIMEOUT  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dma_16_en    (dma_16_en),
    .dsp_req8     (dsp_req8),
    .dsp_req16    (dsp_req16),
    .dsp_ack8     (dsp_ack8),
    .dsp_ack16    (dsp_ack16),
    .dsp_readdata (dsp_readdata),
    .dsp_writedata(dsp_writedata),
    .dma_req8     (dma_req8),
    .dma_req16    (dma_req16),
    .dma_ack      (dma_ack),
    .dma_readdata (dma_readdata),
    .dma_writedata(dma_writedata),
    .busy         (busy),
    .err          (err),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (dsp_ack8 && dsp_ack16) dual = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input string nm);
    int k = 0;
    while (!(dma_req8 || dma_req16) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_timeout"}, (k >= 20) ? 1 : 0, 0);
  endtask

  task automatic ack(input logic [15:0] d);
    dma_ack      = 1'b1;
    dma_readdata = d;
    @(negedge clk);
    dma_ack      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dsp_req8 = 1'b0; dsp_req16 = 1'b0;
    dma_ack = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Both held from reset: 8 x4, 16 x4, then 8; then single-requester routing
    vt[0]  = '{1, 1, 1, 16'h1000, 16'hA000, 1, 0, 1, 0};
    vt[1]  = '{1, 1, 1, 16'h1001, 16'hA001, 1, 0, 1, 0};
    vt[2]  = '{1, 1, 1, 16'h1002, 16'hA002, 1, 0, 1, 0};
    vt[3]  = '{1, 1, 1, 16'h1003, 16'hA003, 1, 0, 1, 0};
    vt[4]  = '{1, 1, 1, 16'h1004, 16'hA004, 0, 1, 0, 1};
    vt[5]  = '{1, 1, 1, 16'h1005, 16'hA005, 0, 1, 0, 1};
    vt[6]  = '{1, 1, 1, 16'h1006, 16'hA006, 0, 1, 0, 1};
    vt[7]  = '{1, 1, 1, 16'h1007, 16'hA007, 0, 1, 0, 1};
    vt[8]  = '{1, 1, 1, 16'h1008, 16'hA008, 1, 0, 1, 0};
    vt[9]  = '{0, 1, 0, 16'h1009, 16'hA009, 1, 0, 0, 1};
    vt[10] = '{0, 1, 1, 16'h100A, 16'hA00A, 0, 1, 0, 1};
    vt[11] = '{1, 0, 0, 16'h100B, 16'hA00B, 1, 0, 1, 0};

    rst = 1'b1;
    dma_16_en = 1'b0; dsp_req8 = 1'b0; dsp_req16 = 1'b0;
    dsp_writedata = '0; dma_ack = 1'b0; dma_readdata = '0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {dma_req8, dma_req16, dsp_ack8, dsp_ack16, busy, err}, 0);
    chk("reset_data", {dsp_readdata, dma_writedata}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      dsp_req8      = vt[i].r8;
      dsp_req16     = vt[i].r16;
      dma_16_en     = vt[i].en;
      dsp_writedata = vt[i].wd;
      wait_req($sformatf("v%0d", i));
      chk($sformatf("v%0d_route", i), {dma_req8, dma_req16},
          {vt[i].e8, vt[i].e16});
      chk($sformatf("v%0d_wdata", i), dma_writedata, vt[i].wd);
      ack(vt[i].rd);
      chk($sformatf("v%0d_ack", i), {dsp_ack8, dsp_ack16},
          {vt[i].a8, vt[i].a16});
      chk($sformatf("v%0d_rdata", i), dsp_readdata, vt[i].rd);
      chk($sformatf("v%0d_reqdrop", i), {dma_req8, dma_req16}, 0);
    end
    dsp_req8 = 1'b0; dsp_req16 = 1'b0;
    do_reset();

    // Single 8-bit request: one-cycle latency, ack one cycle after dma_ack
    dsp_req8 = 1'b1; dma_16_en = 1'b1; dsp_writedata = 16'hBEEF;
    chk("t1_pre", dma_req8, 0);
    @(negedge clk);
    chk("t1_latency", {dma_req8, dma_req16}, 2'b10);
    chk("t1_wdata", dma_writedata, 16'hBEEF);
    dsp_req8 = 1'b0;
    @(negedge clk);
    chk("t1_hold_after_drop", dma_req8, 1);
    ack(16'h1234);
    chk("t1_ack", {dsp_ack8, dsp_ack16}, 2'b10);
    chk("t1_rdata", dsp_readdata, 16'h1234);
    chk("t1_recov", {dma_req8, busy}, 2'b01);
    @(negedge clk);
    chk("t1_pulse", {dsp_ack8, busy}, 0);
    ack(16'h5555);
    chk("idle_ack_ignored", {dsp_ack8, dsp_ack16, busy}, 0);
    chk("idle_ack_rdata", dsp_readdata, 16'h1234);

    // dma_16_en flips mid-grant: ch5 held, next grant on ch1
    dsp_req16 = 1'b1; dma_16_en = 1'b1;
    wait_req("t4a");
    chk("t4_ch5", {dma_req8, dma_req16}, 2'b01);
    dma_16_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_ch5_held", {dma_req8, dma_req16}, 2'b01);
    ack(16'h4444);
    chk("t4_ack16", {dsp_ack8, dsp_ack16}, 2'b01);
    wait_req("t4b");
    chk("t4_ch1", {dma_req8, dma_req16}, 2'b10);
    dsp_req16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_ch1_held", dma_req8, 1);
    ack(16'h4545);
    chk("t4_ack16_ch1", {dsp_ack8, dsp_ack16}, 2'b01);
    chk("t4_rdata", dsp_readdata, 16'h4545);
    @(negedge clk);

    // Asynchronous reset in the middle of a grant
    dsp_req8 = 1'b1; dma_16_en = 1'b1;
    wait_req("t5");
    #2 rst = 1'b1;
    #1 chk("t5_async_drop", {dma_req8, dma_req16, busy}, 0);
    dsp_req8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ack(16'h7777);
    chk("t5_no_ack", {dsp_ack8, dsp_ack16, dma_req8}, 0);
    @(negedge clk);

`ifdef SOUND_DMA_TIMEOUT_EN
    begin
      int n = 0;
      bit seen = 1'b0;
      dsp_req8 = 1'b1;
      wait_req("t6");
      dsp_req8 = 1'b0;
      while (dma_req8 && n < 40) begin
        if (dsp_ack8) seen = 1'b1;
        n++;
        @(negedge clk);
      end
      chk("t6_grant_len", n, 16);
      chk("t6_err", err, 1);
      chk("t6_no_ack", {seen, dsp_ack8, dsp_ack16}, 0);
      repeat (2) @(negedge clk);
      chk("t6_err_sticky", err, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("t6_err_clr", err, 0);
    end
`else
    dsp_req8 = 1'b1;
    wait_req("t6");
    dsp_req8 = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_timeout", {dma_req8, err}, 2'b10);
    ack(16'h6666);
    chk("t6_late_ack", {dsp_ack8, dsp_readdata}, {1'b1, 16'h6666});
`endif

    @(negedge clk);
    chk("no_dual_ack", dual, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
